legv8_fetch_unit: RTL and testbench
===================================

// Module: legv8_fetch_unit
// PURPOSE
//   Instruction-fetch front end for the LEGv8 core: the producer side of the
//   control unit's instruction input. Holds the PC, requests words from
//   instruction memory, presents each fetched word to the control unit with
//   a valid/ready handshake, and computes the next PC (sequential, PC-relative
//   branch, register target) from the redirect fields returned at acceptance.
// PARAMETERS
//   ADDR_W    64     PC / memory address width in bits
//   RESET_PC  64'h0  PC value loaded on reset
// PORTS
//   clock         in   1       rising-edge clock
//   reset         in   1       synchronous, active-low (0 = reset)
//   imem_req      out  1       instruction-memory read request
//   imem_addr     out  ADDR_W  read address; equals pc while imem_req=1
//   imem_ack      in   1       read data valid this cycle
//   imem_rdata    in   32      instruction word
//   instruction   out  32      word presented to the control unit
//   instr_valid   out  1       instruction holds a word not yet accepted
//   instr_ready   in   1       control unit accepts the word this cycle
//   pc_sel        in   2       00 PC+4, 01 PC+(constant<<2), 10 reg_target, 11 PC+4
//   branch_taken  in   1       qualifies pc_sel=01; 0 forces PC+4
//   constant      in   ADDR_W  sign-extended word offset from the control unit
//   reg_target    in   ADDR_W  absolute target for BR
//   pc            out  ADDR_W  address of the presented instruction
//   pc_plus4      out  ADDR_W  pc+4 (link value for BL)
//   issue_count   out  32      instructions accepted since reset
// BEHAVIOUR
//   - Reset (reset=0 at posedge): state=IDLE, pc=RESET_PC, imem_req=0,
//     instr_valid=0, instruction=0, issue_count=0. Applies in any state.
//   - States:
//     IDLE -> REQ on the first clock with reset=1.
//     REQ: imem_req=1, imem_addr=pc. On imem_ack=1: capture imem_rdata into
//       instruction, -> HOLD. Zero-wait memory (ack in the first REQ cycle)
//       is legal. imem_addr is stable for the whole REQ.
//     HOLD: instr_valid=1, imem_req=0, instruction stable. On instr_ready=1:
//       sample pc_sel/branch_taken/constant/reg_target in that cycle, load
//       next pc, issue_count+=1, -> REQ.
//   - Next PC: seq = pc+4; rel = pc + (constant<<2), only when pc_sel=01 and
//     branch_taken=1; reg = reg_target. All sums mod 2^ADDR_W (wrap silently).
//     reg_target is used as given, with no alignment check.
//   - Throughput: one instruction per 2 cycles minimum (REQ+HOLD, zero-wait).
//   - imem_ack outside REQ (IDLE or HOLD) is ignored, with no state change.
//     This covers a stale ack arriving after reset aborts a fetch.
//   - instr_ready outside HOLD is ignored.
//   - issue_count wraps from 32'hFFFF_FFFF to 0.
//   - pc_plus4 = pc+4 combinationally, valid in every state.
// TESTING
//   1 Reset then zero-wait memory with MOVZ X1,1 (32'hD2800021) at addr 0 ->
//     imem_req on the first cycle after reset release, addr 0; next cycle
//     instr_valid=1, instruction=32'hD2800021, pc=0; ready (pc_sel=00) ->
//     next imem_addr=4, issue_count=1.
//   2 BL 10 at pc 20: pc_sel=01, branch_taken=1, constant=10 -> pc_plus4=24
//     while presented; next imem_addr=60.
//   3 B -7 at pc 32: constant=64'hFFFF_FFFF_FFFF_FFF9, branch_taken=1 ->
//     next addr 4. CBZ not taken (branch_taken=0) at pc 36 -> next addr 40.
//   4 BR X30: pc_sel=10, reg_target=64'h18 -> next addr 0x18.
//     pc=64'hFFFF_FFFF_FFFF_FFFC with seq -> next addr 0 (wrap).
//   5 Memory ack after 3 wait cycles -> imem_req=1 and imem_addr held for all
//     4 REQ cycles. Hold instr_ready=0 for 5 cycles in HOLD -> instruction,
//     pc and instr_valid unchanged, imem_req=0.
//   6 Assert reset during REQ, then ack 1 cycle after reset release
//     (state IDLE) -> ack ignored; pc=RESET_PC; next fetch addr RESET_PC;
//     issue_count=0.

Source files
------------

// File: rtl/legv8_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory read port plus the instruction
// handshake and redirect fields exchanged with the control unit.
interface legv8_fetch_unit_if #(
   parameter int unsigned ADDR_W = 64
);
   localparam int unsigned INSTR_W = 32;
   localparam int unsigned CNT_W   = 32;

   logic                 imem_req;
   logic [ADDR_W-1:0]    imem_addr;
   logic                 imem_ack;
   logic [INSTR_W-1:0]   imem_rdata;
   logic [INSTR_W-1:0]   instruction;
   logic                 instr_valid;
   logic                 instr_ready;
   logic [1:0]           pc_sel;
   logic                 branch_taken;
   logic [ADDR_W-1:0]    constant;
   logic [ADDR_W-1:0]    reg_target;
   logic [ADDR_W-1:0]    pc;
   logic [ADDR_W-1:0]    pc_plus4;
   logic [CNT_W-1:0]     issue_count;

   // Fetch-unit side
   modport master (
      output imem_req, imem_addr, instruction, instr_valid, pc, pc_plus4, issue_count,
      input  imem_ack, imem_rdata, instr_ready, pc_sel, branch_taken, constant, reg_target
   );

   // Memory / control-unit side
   modport slave (
      input  imem_req, imem_addr, instruction, instr_valid, pc, pc_plus4, issue_count,
      output imem_ack, imem_rdata, instr_ready, pc_sel, branch_taken, constant, reg_target
   );
endinterface

// File: rtl/legv8_fetch_unit.sv
// LEGv8 instruction-fetch front end: fetches one word per PC, presents it with
// valid/ready, and redirects the PC from the fields returned at acceptance.
module legv8_fetch_unit #(
   parameter int unsigned     ADDR_W   = 64,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input logic               clock,
   input logic               reset,
   legv8_fetch_unit_if.master bus
);
   localparam int unsigned INSTR_W = 32;
   localparam int unsigned CNT_W   = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t               state;
   logic [ADDR_W-1:0]    pc_q;
   logic                 imem_req_q;
   logic                 instr_valid_q;
   logic [INSTR_W-1:0]   instruction_q;
   logic [CNT_W-1:0]     issue_count_q;
   logic [ADDR_W-1:0]    next_pc;

   // Redirect selection; a relative target needs both pc_sel=01 and a taken branch
   always_comb begin
      next_pc = pc_q + ADDR_W'(4);
      if (bus.pc_sel == 2'b10) begin
         next_pc = bus.reg_target;
      end else if (bus.pc_sel == 2'b01 && bus.branch_taken) begin
         next_pc = pc_q + (bus.constant << 2);
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state         <= IDLE;
         pc_q          <= RESET_PC;
         imem_req_q    <= 1'b0;
         instr_valid_q <= 1'b0;
         instruction_q <= '0;
         issue_count_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               state      <= REQ;
               imem_req_q <= 1'b1;
            end
            REQ: begin
               if (bus.imem_ack) begin
                  instruction_q <= bus.imem_rdata;
                  imem_req_q    <= 1'b0;
                  instr_valid_q <= 1'b1;
                  state         <= HOLD;
               end
            end
            HOLD: begin
               if (bus.instr_ready) begin
                  pc_q          <= next_pc;
                  issue_count_q <= issue_count_q + CNT_W'(1);
                  instr_valid_q <= 1'b0;
                  imem_req_q    <= 1'b1;
                  state         <= REQ;
               end
            end
            default: begin
               state         <= IDLE;
               imem_req_q    <= 1'b0;
               instr_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.imem_req    = imem_req_q;
   assign bus.imem_addr   = pc_q;
   assign bus.instruction = instruction_q;
   assign bus.instr_valid = instr_valid_q;
   assign bus.pc          = pc_q;
   assign bus.pc_plus4    = pc_q + ADDR_W'(4);
   assign bus.issue_count = issue_count_q;
endmodule

// File: tb/tb_legv8_fetch_unit.sv
// Directed bench for legv8_fetch_unit: a transaction-level PC/count model
// checked every cycle, plus hand-computed expectations along a fixed path.
module tb_legv8_fetch_unit;
   localparam int unsigned ADDR_W = 64;
   localparam logic [63:0] RST_PC = 64'h0;

   logic clock;
   logic reset;
   int   tests;
   int   fails;
   int   n_acc;

   logic [63:0] m_pc;
   int unsigned m_count;
   bit          live;

   legv8_fetch_unit_if #(.ADDR_W(ADDR_W)) bus ();

   legv8_fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(RST_PC)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Instruction memory contents: MOVZ X1,1 at 0, address-derived words elsewhere
   function automatic logic [31:0] mem(input logic [63:0] a);
      if (a == 64'h0) return 32'hD280_0021;
      return (a[31:0] * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   // Architectural next-PC rule
   function automatic logic [63:0] model_next(input logic [63:0] p, input logic [1:0] sel,
                                              input logic bt, input logic [63:0] c,
                                              input logic [63:0] rt);
      if (sel == 2'b10) return rt;
      if (sel == 2'b01 && bt) return p + c * 64'd4;
      return p + 64'd4;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Model update at each accepted instruction
   always @(posedge clock) begin
      if (!reset) begin
         m_pc    <= RST_PC;
         m_count <= 0;
         live    <= 1'b1;
      end else if (bus.instr_valid === 1'b1 && bus.instr_ready === 1'b1) begin
         m_pc    <= model_next(m_pc, bus.pc_sel, bus.branch_taken, bus.constant, bus.reg_target);
         m_count <= m_count + 1;
      end
   end

   // Per-cycle comparison against the model
   always @(negedge clock) begin
      if (live) begin
         chk("m_pc", bus.pc, m_pc);
         chk("m_pc_plus4", bus.pc_plus4, m_pc + 64'd4);
         chk("m_issue_count", 64'(bus.issue_count), 64'(m_count));
         chk("m_req_valid_excl", 64'(bus.imem_req & bus.instr_valid), 64'h0);
         if (bus.imem_req === 1'b1) chk("m_imem_addr", bus.imem_addr, m_pc);
         if (bus.instr_valid === 1'b1) chk("m_instruction", 64'(bus.instruction), 64'(mem(m_pc)));
      end
   end

   // Wait for a request, hold off the ack for 'waits' cycles, then return the word
   task automatic do_fetch(input int waits, input logic [63:0] exp_addr);
      int n = 0;
      while (bus.imem_req !== 1'b1 && n < 10) begin
         @(posedge clock); #1;
         n++;
      end
      if (n >= 10) begin
         chk("req_timeout", 64'(bus.imem_req), 64'h1);
         return;
      end
      for (int i = 0; i < waits; i++) begin
         chk("req_held", 64'(bus.imem_req), 64'h1);
         chk("addr_held", bus.imem_addr, exp_addr);
         chk("valid_low_in_req", 64'(bus.instr_valid), 64'h0);
         @(posedge clock); #1;
      end
      chk("req_addr", bus.imem_addr, exp_addr);
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = mem(bus.imem_addr);
      @(posedge clock); #1;
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = $urandom;
      chk("valid_after_ack", 64'(bus.instr_valid), 64'h1);
      chk("req_low_in_hold", 64'(bus.imem_req), 64'h0);
   endtask

   // Stall 'holds' cycles (with stray acks), then accept with the given redirect
   task automatic accept(input logic [1:0] sel, input logic bt, input logic [63:0] c,
                         input logic [63:0] rt, input int holds,
                         input logic [63:0] cur_pc, input logic [63:0] exp_next);
      for (int i = 0; i < holds; i++) begin
         bus.instr_ready  = 1'b0;
         bus.imem_ack     = 1'b1;
         bus.imem_rdata   = $urandom;
         bus.pc_sel       = 2'($urandom);
         bus.branch_taken = 1'($urandom);
         @(posedge clock); #1;
         chk("hold_valid", 64'(bus.instr_valid), 64'h1);
         chk("hold_req", 64'(bus.imem_req), 64'h0);
         chk("hold_instr", 64'(bus.instruction), 64'(mem(cur_pc)));
         chk("hold_pc", bus.pc, cur_pc);
      end
      bus.imem_ack     = 1'b0;
      bus.pc_sel       = sel;
      bus.branch_taken = bt;
      bus.constant     = c;
      bus.reg_target   = rt;
      bus.instr_ready  = 1'b1;
      chk("pc_plus4", bus.pc_plus4, cur_pc + 64'd4);
      @(posedge clock); #1;
      bus.instr_ready  = 1'b0;
      bus.constant     = {$urandom, $urandom};
      bus.reg_target   = {$urandom, $urandom};
      n_acc++;
      chk("next_req", 64'(bus.imem_req), 64'h1);
      chk("next_addr", bus.imem_addr, exp_next);
      chk("next_valid", 64'(bus.instr_valid), 64'h0);
      chk("issue_count", 64'(bus.issue_count), 64'(n_acc));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      tests = 0; fails = 0; n_acc = 0; live = 1'b0;
      reset = 1'b0;
      bus.imem_ack = 1'b0; bus.imem_rdata = 32'h0; bus.instr_ready = 1'b0;
      bus.pc_sel = 2'b00; bus.branch_taken = 1'b0; bus.constant = '0; bus.reg_target = '0;
      repeat (2) @(posedge clock);
      #1;
      chk("rst_req", 64'(bus.imem_req), 64'h0);
      chk("rst_valid", 64'(bus.instr_valid), 64'h0);
      chk("rst_instr", 64'(bus.instruction), 64'h0);
      chk("rst_count", 64'(bus.issue_count), 64'h0);
      chk("rst_pc", bus.pc, 64'h0);
      reset = 1'b1;
      @(posedge clock); #1;
      chk("first_req", 64'(bus.imem_req), 64'h1);
      chk("first_addr", bus.imem_addr, 64'h0);

      // Zero-wait fetch of MOVZ X1,1
      do_fetch(0, 64'h0);
      chk("movz_word", 64'(bus.instruction), 64'h0000_0000_D280_0021);
      chk("movz_pc", bus.pc, 64'h0);
      accept(2'b00, 1'b0, 64'h0, 64'h0, 0, 64'h0, 64'h4);

      // Slow memory and a stalled consumer, then BR to 20
      do_fetch(3, 64'h4);
      accept(2'b10, 1'b0, 64'h0, 64'd20, 5, 64'h4, 64'd20);
      // BL 10 at pc 20
      do_fetch(0, 64'd20);
      accept(2'b01, 1'b1, 64'd10, 64'h0, 0, 64'd20, 64'd60);
      do_fetch(0, 64'd60);
      accept(2'b10, 1'b0, 64'h0, 64'd32, 0, 64'd60, 64'd32);
      // B -7 at pc 32
      do_fetch(1, 64'd32);
      accept(2'b01, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'h0, 0, 64'd32, 64'd4);
      do_fetch(0, 64'd4);
      accept(2'b10, 1'b0, 64'h0, 64'd36, 0, 64'd4, 64'd36);
      // CBZ not taken at pc 36
      do_fetch(0, 64'd36);
      accept(2'b01, 1'b0, 64'd100, 64'h0, 0, 64'd36, 64'd40);
      // pc_sel=11 and a stray branch_taken with pc_sel=00 both fall through
      do_fetch(0, 64'd40);
      accept(2'b11, 1'b1, 64'd5, 64'h1234, 0, 64'd40, 64'd44);
      do_fetch(0, 64'd44);
      accept(2'b00, 1'b1, 64'd5, 64'h1234, 0, 64'd44, 64'd48);
      // BR X30 = 0x18, then jump to the top of the address space and wrap
      do_fetch(0, 64'd48);
      accept(2'b10, 1'b0, 64'h0, 64'h18, 0, 64'd48, 64'h18);
      do_fetch(0, 64'h18);
      accept(2'b10, 1'b0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 0, 64'h18, 64'hFFFF_FFFF_FFFF_FFFC);
      do_fetch(2, 64'hFFFF_FFFF_FFFF_FFFC);
      accept(2'b00, 1'b0, 64'h0, 64'h0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0);

      // Reset in the middle of a request; stale ack lands while idle
      reset = 1'b0;
      @(posedge clock); #1;
      n_acc = 0;
      reset = 1'b1;
      bus.imem_ack = 1'b1;
      bus.imem_rdata = 32'hDEAD_BEEF;
      chk("abort_req", 64'(bus.imem_req), 64'h0);
      chk("abort_count", 64'(bus.issue_count), 64'h0);
      @(posedge clock); #1;
      bus.imem_ack = 1'b0;
      chk("stale_req", 64'(bus.imem_req), 64'h1);
      chk("stale_addr", bus.imem_addr, RST_PC);
      chk("stale_valid", 64'(bus.instr_valid), 64'h0);
      chk("stale_pc", bus.pc, RST_PC);
      chk("stale_count", 64'(bus.issue_count), 64'h0);
      do_fetch(0, RST_PC);
      chk("refetch_word", 64'(bus.instruction), 64'h0000_0000_D280_0021);
      accept(2'b00, 1'b0, 64'h0, 64'h0, 0, RST_PC, 64'h4);

      @(posedge clock); #1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
